fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single write port of a fifo instance (in_vld/in_data/full) between NUM_REQ producers.
- Grants one requester at a time for a bounded burst of up to MAX_BURST beats.
- Applies fifo backpressure to the granted requester only.
- Rotates priority after every burst.
- Sits directly in front of the fifo write side; the fifo read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo write port between NUM_REQ producers.
// Each grant covers a burst of up to MAX_BURST beats, with one idle cycle between grants.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned WIDTH     = 6,
   parameter int unsigned MAX_BURST = 4,
   localparam int unsigned IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_vld_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]       req_rdy_o,
   input  logic                     fifo_full_i,
   output logic                     fifo_in_vld_o,
   output logic [WIDTH-1:0]         fifo_in_data_o,
   output logic [NUM_REQ-1:0]       grant_o,
   output logic [IdW-1:0]           grant_id_o,
   output logic                     busy_o
);

   typedef enum logic {StIdle, StBurst} state_e;

   state_e               state_q, state_d;
   logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]       gid_q, gid_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [7:0]           beat_cnt_q, beat_cnt_d;

   logic [IdW-1:0]       sel;
   logic                 sel_vld;
   logic                 g_vld;
   logic [WIDTH-1:0]     g_data;
   logic                 xfer;
   logic                 last_beat;

   // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned    idx;
      logic [IdW-1:0] idx_w;
      sel     = rr_ptr_q;
      sel_vld = 1'b0;
      idx     = 0;
      idx_w   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx   = (32'(rr_ptr_q) + i) % NUM_REQ;
         idx_w = idx[IdW-1:0];
         if (!sel_vld && req_vld_i[idx_w]) begin
            sel     = idx_w;
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      g_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (gid_q == IdW'(k)) begin
            g_data = req_data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign g_vld     = req_vld_i[gid_q];
   assign xfer      = g_vld & ~fifo_full_i;
   assign last_beat = (beat_cnt_q == 8'(MAX_BURST - 1));

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      gid_d          = gid_q;
      grant_d        = grant_q;
      beat_cnt_d     = beat_cnt_q;
      req_rdy_o      = '0;
      fifo_in_vld_o  = 1'b0;
      fifo_in_data_o = '0;
      busy_o         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sel_vld && !fifo_full_i) begin
               state_d    = StBurst;
               gid_d      = sel;
               grant_d    = NUM_REQ'(1) << sel;
               beat_cnt_d = '0;
            end
         end
         StBurst: begin
            busy_o         = 1'b1;
            req_rdy_o      = grant_q & {NUM_REQ{~fifo_full_i}};
            fifo_in_vld_o  = xfer;
            fifo_in_data_o = g_data;
            // An idle requester releases even while the fifo is full.
            if (!g_vld || (xfer && last_beat)) begin
               state_d    = StIdle;
               grant_d    = '0;
               beat_cnt_d = '0;
               rr_ptr_d   = (gid_q == IdW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         gid_q      <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gid_q      <= gid_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign grant_o    = grant_q;
   assign grant_id_o = gid_q;

endmodule
